// File: rtl/prog_loader_if.sv
// ============================================================================
// Module : prog_loader_if
// Brief  : Byte-stream valid/ready channel feeding the program loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface prog_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module : prog_loader
// Brief  : Boot loader; frames a byte stream into W-bit words, fills the
//          instruction memory from address 0 and then releases core reset.
//          Optional trailing XOR checksum byte: define PROG_LOADER_CKSUM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic              clk,
    input  logic              reset,
    prog_loader_if.slave      stream,
    input  logic              restart,
    output logic              im_wr_en,
    output logic [D-1:0]      im_addr,
    output logic [W-1:0]      im_wr_data,
    output logic              core_reset,
    output logic              load_done,
    output logic              err
);

    localparam int          CW        = D + 1;
    localparam logic [16:0] C_MAX_LEN = 17'd1 << D;

    typedef enum logic [2:0] {
        S_LEN_LO  = 3'd0,
        S_LEN_HI  = 3'd1,
        S_WORD_LO = 3'd2,
        S_WORD_HI = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5,
        S_CKSUM   = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    state_t          w_after_words;
    logic            w_ready;
    logic            w_accept;
    logic [15:0]     w_len;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_hi_bad;

    logic [15:0]     r_len;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_lo;
    logic            r_wr_en;
    logic [D-1:0]    r_addr;
    logic [W-1:0]    r_wr_data;
    logic            r_core_reset;

`ifdef PROG_LOADER_CKSUM_EN
    logic [7:0]      r_x;
    assign w_after_words = S_CKSUM;
`else
    assign w_after_words = S_DONE;
`endif

    assign w_len     = {stream.in_data, r_len[7:0]};
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_hi_bad  = |stream.in_data[7:1];
    assign w_accept  = stream.in_valid && w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LEN_LO;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_LEN_LO: begin
                w_ready = 1'b1;
                if (stream.in_valid) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                w_ready = 1'b1;
                if (stream.in_valid) begin
                    if ({1'b0, w_len} > C_MAX_LEN) w_next = S_ERR;
                    else if (w_len == 16'd0)        w_next = w_after_words;
                    else                            w_next = S_WORD_LO;
                end
            end
            S_WORD_LO: begin
                w_ready = 1'b1;
                if (stream.in_valid) w_next = S_WORD_HI;
            end
            S_WORD_HI: begin
                w_ready = 1'b1;
                if (stream.in_valid) begin
                    if (w_hi_bad)                              w_next = S_ERR;
                    else if (17'(w_cnt_inc) < {1'b0, r_len})   w_next = S_WORD_LO;
                    else                                       w_next = w_after_words;
                end
            end
`ifdef PROG_LOADER_CKSUM_EN
            S_CKSUM: begin
                w_ready = 1'b1;
                if (stream.in_valid) begin
                    w_next = (stream.in_data == r_x) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE: begin
                if (restart) w_next = S_LEN_LO;
            end
            S_ERR: begin
                w_next = S_ERR;
            end
            default: begin
                w_next = S_ERR;
            end
        endcase
    end

    // Write strobe lands one cycle after the high byte; core_reset lags DONE by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len        <= 16'd0;
            r_cnt        <= '0;
            r_lo         <= 8'd0;
            r_wr_en      <= 1'b0;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_core_reset <= 1'b1;
        end else begin
            r_wr_en      <= 1'b0;
            r_core_reset <= (r_state != S_DONE) || restart;
            case (r_state)
                S_LEN_LO: if (w_accept) r_len[7:0] <= stream.in_data;
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= stream.in_data;
                        r_cnt       <= '0;
                    end
                end
                S_WORD_LO: if (w_accept) r_lo <= stream.in_data;
                S_WORD_HI: begin
                    if (w_accept && !w_hi_bad) begin
                        r_wr_en   <= 1'b1;
                        r_addr    <= r_cnt[D-1:0];
                        r_wr_data <= W'({stream.in_data[0], r_lo});
                        r_cnt     <= w_cnt_inc;
                    end
                end
                S_DONE: begin
                    if (restart) begin
                        r_cnt  <= '0;
                        r_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PROG_LOADER_CKSUM_EN
    // Running XOR over every payload byte that follows the length field.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x <= 8'd0;
        end else if (r_state == S_LEN_LO) begin
            r_x <= 8'd0;
        end else if (w_accept && (r_state == S_WORD_LO || r_state == S_WORD_HI)) begin
            r_x <= r_x ^ stream.in_data;
        end
    end
`endif

    assign stream.in_ready = w_ready;
    assign im_wr_en        = r_wr_en;
    assign im_addr         = r_addr;
    assign im_wr_data      = r_wr_data;
    assign core_reset      = r_core_reset;
    assign load_done       = (r_state == S_DONE);
    assign err             = (r_state == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module : tb_prog_loader
// Brief  : Self-checking bench for prog_loader: vector table, corner
//          sequences and random frames against a frame-parsing model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

    localparam int D = 12;
    localparam int W = 9;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        string       nm;
        int          n;
        logic [63:0] bytes;
        int          gap;
        int          nwr;
        logic [8:0]  d0;
        logic [8:0]  d1;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             restart;
    logic             im_wr_en;
    logic [D-1:0]     im_addr;
    logic [W-1:0]     im_wr_data;
    logic             core_reset;
    logic             load_done;
    logic             err;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               viol    = 0;
    logic [D+W-1:0]   wq[$];
    logic [D+W-1:0]   mq[$];
    int               m_cons;
    int               m_stat;
    vec_t             tbl[7];

    prog_loader_if bus();

    prog_loader #(.D(D), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .stream     (bus),
        .restart    (restart),
        .im_wr_en   (im_wr_en),
        .im_addr    (im_addr),
        .im_wr_data (im_wr_data),
        .core_reset (core_reset),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_wr_en) begin
            wq.push_back({im_addr, im_wr_data});
            if (!core_reset) viol++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: parse the frame into expected writes, bytes consumed and end status
    // (0 = still loading, 1 = done, 2 = error).
    task automatic model_run(input bq_t s);
        int         n;
        logic [7:0] x;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [D-1:0] a;
        mq.delete();
        m_cons = 0;
        m_stat = 0;
        x      = 8'd0;
        if (s.size() < 2) return;
        n      = int'({s[1], s[0]});
        m_cons = 2;
        if (n > (1 << D)) begin
            m_stat = 2;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (s.size() < 4 + 2 * i) return;
            lo = s[2 + 2 * i];
            hi = s[3 + 2 * i];
            m_cons += 2;
            if (hi > 8'd1) begin
                m_stat = 2;
                return;
            end
            a = i[D-1:0];
            mq.push_back({a, hi[0], lo});
            x = x ^ lo ^ hi;
        end
`ifdef PROG_LOADER_CKSUM_EN
        if (s.size() <= m_cons) return;
        m_cons++;
        m_stat = (s[m_cons - 1] == x) ? 1 : 2;
`else
        m_stat = 1;
`endif
    endtask

    function automatic bq_t with_ck(input bq_t s);
        bq_t        r;
        logic [7:0] x;
        r = s;
        x = 8'd0;
        for (int i = 2; i < r.size(); i++) x = x ^ r[i];
`ifdef PROG_LOADER_CKSUM_EN
        r.push_back(x);
`endif
        return r;
    endfunction

    task automatic do_reset();
        reset        = 1'b1;
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: byte 0x%0h got no in_ready, required in_ready", b);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_frame(input bq_t s, input int gapmode);
        model_run(s);
        wq.delete();
        for (int i = 0; i < m_cons; i++)
            send(s[i], (gapmode == 2) ? int'($urandom_range(0, 2)) : gapmode);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_model(input string p);
        chk({p, "_nwr"}, wq.size(), mq.size());
        for (int i = 0; i < wq.size() && i < mq.size(); i++)
            chk($sformatf("%s_wr%0d", p, i), wq[i], mq[i]);
        chk({p, "_done"},  load_done,    (m_stat == 1));
        chk({p, "_err"},   err,          (m_stat == 2));
        chk({p, "_crst"},  core_reset,   (m_stat != 1));
        chk({p, "_ready"}, bus.in_ready, (m_stat == 0));
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_wr_en"}, im_wr_en,     0);
        chk({p, "_addr"},  im_addr,      0);
        chk({p, "_data"},  im_wr_data,   0);
        chk({p, "_crst"},  core_reset,   1);
        chk({p, "_done"},  load_done,    0);
        chk({p, "_err"},   err,          0);
        chk({p, "_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        bq_t        s;
        int         n;
        int         kind;
        logic [8:0] w;
        logic [7:0] hi;

        tbl[0] = '{"two_words",  6, 64'h0000_0007_014A_0002, 0, 2, 9'h14A, 9'h007, 1'b1, 1'b0};
        tbl[1] = '{"two_toggle", 6, 64'h0000_0007_014A_0002, 1, 2, 9'h14A, 9'h007, 1'b1, 1'b0};
        tbl[2] = '{"bad_hi",     4, 64'h0000_0000_0212_0001, 0, 0, 9'h000, 9'h000, 1'b0, 1'b1};
        tbl[3] = '{"n_4097",     2, 64'h0000_0000_0000_1001, 0, 0, 9'h000, 9'h000, 1'b0, 1'b1};
        tbl[4] = '{"n_zero",     2, 64'h0000_0000_0000_0000, 0, 0, 9'h000, 9'h000, 1'b1, 1'b0};
        tbl[5] = '{"one_ff",     4, 64'h0000_0000_00FF_0001, 1, 1, 9'h0FF, 9'h000, 1'b1, 1'b0};
        tbl[6] = '{"hi_80",      4, 64'h0000_0000_8000_0001, 0, 0, 9'h000, 9'h000, 1'b0, 1'b1};

        bus.in_data  = 8'd0;
        bus.in_valid = 1'b0;
        restart      = 1'b0;
        reset        = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();
        chk_reset_vals("rst");

        foreach (tbl[k]) begin
            do_reset();
            s.delete();
            for (int i = 0; i < tbl[k].n; i++) s.push_back(tbl[k].bytes[8*i +: 8]);
            if (tbl[k].exp_done) s = with_ck(s);
            run_frame(s, tbl[k].gap);
            chk({tbl[k].nm, "_nwr"}, wq.size(), tbl[k].nwr);
            if (tbl[k].nwr > 0) chk({tbl[k].nm, "_wr0"}, wq[0], {12'd0, tbl[k].d0});
            if (tbl[k].nwr > 1) chk({tbl[k].nm, "_wr1"}, wq[1], {12'd1, tbl[k].d1});
            chk({tbl[k].nm, "_done"},  load_done,    tbl[k].exp_done);
            chk({tbl[k].nm, "_err"},   err,          tbl[k].exp_err);
            chk({tbl[k].nm, "_crst"},  core_reset,   !tbl[k].exp_done);
            chk({tbl[k].nm, "_ready"}, bus.in_ready, 1'b0);
        end

        // core_reset must fall exactly one cycle after DONE is entered
        do_reset();
        s = with_ck('{8'h02, 8'h00, 8'h4A, 8'h01, 8'h07, 8'h00});
        model_run(s);
        wq.delete();
        for (int i = 0; i < m_cons; i++) send(s[i], 0);
        chk("seq_done_first", load_done, 1);
        chk("seq_crst_held",  core_reset, 1);
        @(negedge clk);
        chk("seq_crst_fall",  core_reset, 0);
        repeat (2) @(negedge clk);
        check_model("seq");

        pulse_restart();
        chk("rs_crst",  core_reset,   1);
        chk("rs_done",  load_done,    0);
        chk("rs_addr",  im_addr,      0);
        chk("rs_ready", bus.in_ready, 1);
        run_frame(with_ck('{8'h01, 8'h00, 8'hFF, 8'h00}), 0);
        chk("rs_nwr", wq.size(), 1);
        chk("rs_wr0", wq[0], {12'd0, 9'h0FF});
        chk("rs_done2", load_done, 1);

        // reset in the middle of a word after one write has landed
        do_reset();
        send(8'h02, 0); send(8'h00, 0); send(8'h4A, 0); send(8'h01, 0); send(8'hAB, 0);
        do_reset();
        chk_reset_vals("midrst");

        // restart does nothing outside DONE
        run_frame('{8'h01, 8'h00, 8'h12, 8'h02}, 0);
        pulse_restart();
        @(negedge clk);
        chk("err_restart_err",  err,          1);
        chk("err_restart_crst", core_reset,   1);
        chk("err_restart_rdy",  bus.in_ready, 0);

`ifdef PROG_LOADER_CKSUM_EN
        do_reset();
        run_frame('{8'h00, 8'h00, 8'h01}, 0);
        chk("ck_bad_err",  err,        1);
        chk("ck_bad_crst", core_reset, 1);
`endif

        // full-size program: last write lands on the top address
        do_reset();
        s.delete();
        s.push_back(8'h00);
        s.push_back(8'h10);
        for (int i = 0; i < (1 << D); i++) begin
            w = 9'((i * 37) + 5);
            s.push_back(w[7:0]);
            s.push_back({7'd0, w[8]});
        end
        s = with_ck(s);
        run_frame(s, 0);
        check_model("full");
        chk("full_last_addr", wq[wq.size() - 1][D+W-1:W], (1 << D) - 1);

        for (int t = 0; t < 40; t++) begin
            do_reset();
            s.delete();
            kind = int'($urandom_range(0, 9));
            n    = (kind == 0) ? 4097 + int'($urandom_range(0, 100)) : int'($urandom_range(0, 8));
            s.push_back(n[7:0]);
            s.push_back(n[15:8]);
            if (kind != 0) begin
                for (int i = 0; i < n; i++) begin
                    w  = 9'($urandom);
                    hi = {7'd0, w[8]};
                    if (kind == 1 && i == n - 1) hi = hi | 8'h40;
                    s.push_back(w[7:0]);
                    s.push_back(hi);
                end
            end
            s = with_ck(s);
`ifdef PROG_LOADER_CKSUM_EN
            if (kind == 2) s[s.size() - 1] = s[s.size() - 1] ^ 8'h01;
`endif
            run_frame(s, 2);
            check_model($sformatf("rnd%0d", t));
            if (m_stat == 1 && $urandom_range(0, 1) == 1) begin
                pulse_restart();
                chk($sformatf("rnd%0d_restart_crst", t), core_reset, 1);
            end
        end

        chk("wr_after_release", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
